spio_spinn2aer_arbiter: RTL and testbench
=========================================

# spio_spinn2aer_arbiter

Round-robin arbiter that merges up to eight SpiNNaker packet streams into the single 72-bit packet input of the SpiNNaker-to-AER output mapper. It sits directly upstream of the mapper and shares it between requesters. Non-multicast packets are accepted and discarded here. A one-entry output register is reloaded back-to-back, so the mapper never sees a combinational path from the requesters.

## Interface
Parameters:
- NUM_PORTS, 4: number of requester ports; legal range 2..8.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- port_en  in  NUM_PORTS  per-port grant enable; 0 = port never granted.
- ipkt_data  in  NUM_PORTS*72  packet per port; port i occupies [72*i+71:72*i].
- ipkt_vld  in  NUM_PORTS  per-port packet valid.
- ipkt_rdy  out  NUM_PORTS  per-port ready; at most one bit high in any cycle.
- opkt_data  out  72  packet to mapper (registered).
- opkt_vld  out  1  output packet valid (registered).
- opkt_rdy  in  1  mapper ready.
- drop_cnt  out  16  dropped non-multicast packet count; present only with the macro.

## Operation
- Transfer rule, all ports: transfer on a rising edge where vld and rdy are both 1.
- Multicast test: packet is multicast iff data[7:6] == 2'b00.
- Output buffer states:
  - EMPTY: opkt_vld = 0.
  - FULL: opkt_vld = 1; opkt_data is held stable.
- Buffer can load when it is EMPTY, or when it is FULL and opkt_rdy = 1.
- Eligible port: ipkt_vld[i] & port_en[i].
- Winner: first eligible port searching upward, wrapping modulo NUM_PORTS, starting at last_grant+1.
- ipkt_rdy[winner] = can_load. This is combinational from ipkt_vld, port_en, opkt_vld, opkt_rdy and state.
- Winner is multicast:
  - opkt_data <= winner packet; opkt_vld <= 1; state -> FULL.
- Winner is non-multicast:
  - packet is consumed; buffer is not loaded.
  - If the buffer was FULL and opkt_rdy = 1, opkt_vld <= 0 and state -> EMPTY.
- last_grant <= winner on every transfer, multicast or not.
- FULL with opkt_rdy = 1 and no eligible port: opkt_vld <= 0; state -> EMPTY.
- FULL with opkt_rdy = 0: all ipkt_rdy = 0; state and data unchanged.
- Deasserting port_en affects only future arbitration. A packet already in the buffer is delivered.
- All ports disabled: no grants; the buffered packet still drains.

## Timing
- Reset values (rst_n low at an edge):
  - opkt_vld = 0, opkt_data = 0, state EMPTY.
  - last_grant = NUM_PORTS-1, so port 0 wins first.
  - drop_cnt = 0.
- While rst_n = 0, ipkt_rdy is forced to all 0 combinationally.
- Reset mid-transfer discards the buffered packet.
- Latency: input transfer edge to opkt_vld = 1 is one cycle.
- Throughput: one packet per cycle while opkt_rdy stays 1. The mapper itself accepts at most one packet per handshake.
- Fairness: with all ports continuously valid and enabled, each port is granted once every NUM_PORTS transfers.
- No input is ever granted while opkt_vld = 1 and opkt_rdy = 0.

## Configuration
- SPIO_ARB_DROP_CNT_EN defined:
  - drop_cnt port exists.
  - Increments by 1 on each non-multicast transfer, saturating at 16'hFFFF.
  - Cleared only by reset.
- SPIO_ARB_DROP_CNT_EN undefined:
  - drop_cnt port and counter are absent.
  - Non-multicast packets are dropped silently; all other behaviour is identical.

## Structure
- Shared package spio_aer_pkg holds:
  - SPINN_PKT_BITS = 72.
  - PKT_TYPE_MSB = 7, PKT_TYPE_LSB = 6.
  - PKT_TYPE_MC = 2'b00.
  - the 2-state buffer state enum.
  - DROP_CNT_BITS = 16.
- One sub-module: spio_rr_picker, a combinational round-robin selector.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, binary index, any.
- The top level holds last_grant, the output buffer, the state and the optional counter.

## Test plan
- Reset, then port 2 presents multicast 72'h..._0001_0800_00 with opkt_rdy = 1:
  - ipkt_rdy = 4'b0100 same cycle.
  - Next cycle opkt_vld = 1 with identical data.
- Ports 0–3 all valid with multicast packets, opkt_rdy held 1:
  - grants in order 0,1,2,3,0; one output packet per cycle.
- Port 1 presents data[7:6] = 2'b10 (non-multicast), macro defined:
  - ipkt_rdy[1] = 1; opkt_vld stays 0; drop_cnt goes 0 -> 1.
- Buffer FULL, opkt_rdy = 0 for 5 cycles, ports 0 and 3 valid:
  - ipkt_rdy = 0 throughout; opkt_data stable.
  - When opkt_rdy rises, port 0 is granted the same cycle.
- port_en = 4'b1010 with all ports valid:
  - only ports 1 and 3 granted, alternating.
- Assert rst_n = 0 while FULL:
  - next edge opkt_vld = 0 and state EMPTY.
  - After release, port 0 has priority.

Source files
------------

// File: rtl/spio_aer_pkg.sv
// Shared definitions for the SpiNNaker-to-AER output path.
// Holds the packet width, the packet-type field position, the multicast type
// code, the output-buffer state encoding and the drop-counter width, plus a
// helper that classifies a packet as multicast.
package spio_aer_pkg;

  localparam int SPINN_PKT_BITS = 72;
  localparam int PKT_TYPE_MSB   = 7;
  localparam int PKT_TYPE_LSB   = 6;
  localparam logic [1:0] PKT_TYPE_MC = 2'b00;
  localparam int DROP_CNT_BITS  = 16;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  function automatic logic is_mc(input logic [SPINN_PKT_BITS-1:0] pkt);
    return pkt[PKT_TYPE_MSB:PKT_TYPE_LSB] == PKT_TYPE_MC;
  endfunction

endpackage

// File: rtl/spio_rr_picker.sv
// Combinational round-robin selector.
// Searches the request vector upward starting one above last_grant, wrapping
// modulo N, and reports the first set request.
// Ports:
//   req        in  N      request vector
//   last_grant in  IDX_W  index of the previously granted requester
//   gnt        out N      one-hot grant (all zero when nothing requests)
//   idx        out IDX_W  binary index of the granted requester
//   any        out 1      at least one request present
module spio_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = int'(last_grant) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/spio_spinn2aer_arbiter.sv
// Round-robin arbiter merging up to eight SpiNNaker packet streams into the
// single registered packet input of the SpiNNaker-to-AER mapper.
// Non-multicast packets are consumed and discarded. The one-entry output
// register is reloaded back-to-back so the mapper sees only registered outputs.
// Optional feature macro: SPIO_ARB_DROP_CNT_EN adds the saturating drop_cnt port.
// Ports:
//   clk        in  1            rising-edge clock
//   rst_n      in  1            synchronous active-low reset
//   port_en    in  NUM_PORTS    per-port grant enable
//   ipkt_data  in  NUM_PORTS*72 packet per port, port i at [72*i+71:72*i]
//   ipkt_vld   in  NUM_PORTS    per-port valid
//   ipkt_rdy   out NUM_PORTS    per-port ready (at most one bit set)
//   opkt_data  out 72           registered packet to mapper
//   opkt_vld   out 1            registered packet valid
//   opkt_rdy   in  1            mapper ready
//   drop_cnt   out 16           dropped non-multicast count (macro only)
module spio_spinn2aer_arbiter
  import spio_aer_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                port_en,
  input  logic [NUM_PORTS*SPINN_PKT_BITS-1:0] ipkt_data,
  input  logic [NUM_PORTS-1:0]                ipkt_vld,
  output logic [NUM_PORTS-1:0]                ipkt_rdy,
  output logic [SPINN_PKT_BITS-1:0]           opkt_data,
  output logic                                opkt_vld,
  input  logic                                opkt_rdy
`ifdef SPIO_ARB_DROP_CNT_EN
  ,
  output logic [DROP_CNT_BITS-1:0]            drop_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  buf_state_t                r_state;
  buf_state_t                w_state_nxt;
  logic [IDX_W-1:0]          r_last_grant;
  logic [SPINN_PKT_BITS-1:0] r_data;

  logic [NUM_PORTS-1:0]      w_req;
  logic [NUM_PORTS-1:0]      w_gnt;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_any;
  logic                      w_can_load;
  logic                      w_xfer;
  logic                      w_load;
  logic [SPINN_PKT_BITS-1:0] w_win_data;
  logic                      w_win_mc;

  assign w_req = ipkt_vld & port_en;

  spio_rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (w_req),
    .last_grant (r_last_grant),
    .gnt        (w_gnt),
    .idx        (w_idx),
    .any        (w_any)
  );

  // A full buffer may be refilled in the same cycle it is handed to the mapper.
  assign w_can_load = (r_state == BUF_EMPTY) || opkt_rdy;
  assign w_xfer     = rst_n && w_can_load && w_any;
  assign ipkt_rdy   = w_xfer ? w_gnt : '0;

  assign w_win_data = ipkt_data[int'(w_idx)*SPINN_PKT_BITS +: SPINN_PKT_BITS];
  assign w_win_mc   = is_mc(w_win_data);

  // Non-multicast winners fall through to the drain branch: consumed, not loaded.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (w_xfer && w_win_mc) begin
      w_state_nxt = BUF_FULL;
      w_load      = 1'b1;
    end else if (r_state == BUF_FULL && opkt_rdy) begin
      w_state_nxt = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= BUF_EMPTY;
      r_data       <= '0;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_data <= w_win_data;
      if (w_xfer) r_last_grant <= w_idx;
    end
  end

  assign opkt_vld  = (r_state == BUF_FULL);
  assign opkt_data = r_data;

`ifdef SPIO_ARB_DROP_CNT_EN
  logic [DROP_CNT_BITS-1:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_xfer && !w_win_mc && (r_drop_cnt != {DROP_CNT_BITS{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_spio_spinn2aer_arbiter.sv
module tb_spio_spinn2aer_arbiter;

  localparam int NP = 4;
  localparam int PB = 72;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    port_en;
  logic [NP*PB-1:0] ipkt_data;
  logic [NP-1:0]    ipkt_vld;
  logic [NP-1:0]    ipkt_rdy;
  logic [PB-1:0]    opkt_data;
  logic             opkt_vld;
  logic             opkt_rdy;
`ifdef SPIO_ARB_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [PB-1:0] exp_q[$];

  always #5 clk = ~clk;

  spio_spinn2aer_arbiter #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_en   (port_en),
    .ipkt_data (ipkt_data),
    .ipkt_vld  (ipkt_vld),
    .ipkt_rdy  (ipkt_rdy),
    .opkt_data (opkt_data),
    .opkt_vld  (opkt_vld),
    .opkt_rdy  (opkt_rdy)
`ifdef SPIO_ARB_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [PB-1:0] act, input logic [PB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multicast packet: port and sequence tag in the top bytes, type field 00.
  function automatic logic [PB-1:0] mk(input int p, input int s);
    return {8'(p), 8'(s), 48'hC0FF_EE12_3456, 8'h00};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string name, input logic [NP-1:0] exp);
    #1;
    check(name, PB'(ipkt_rdy), PB'(exp));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ipkt_vld = '0;
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic set_all(input int s);
    for (int p = 0; p < NP; p++) ipkt_data[PB*p +: PB] = mk(p, s);
  endtask

  // Scoreboard monitor: every packet handed to the mapper must match the queue head.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && opkt_vld && opkt_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", opkt_data, '0);
          if (opkt_data == '0) begin
            n_errors++;
            $display("FAIL unexpected_out: got %h expected no packet", opkt_data);
          end
        end else begin
          check("out_pkt", opkt_data, exp_q.pop_front());
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    port_en   = '1;
    ipkt_vld  = '1;
    opkt_rdy  = 1'b1;
    ipkt_data = '0;
    set_all(0);
    fork
      monitor();
    join_none

    // Reset state; ipkt_rdy forced low even with requests pending.
    repeat (2) @(posedge clk);
    #2;
    check("rst_vld",  PB'(opkt_vld), '0);
    check("rst_data", opkt_data, '0);
    check("rst_rdy",  PB'(ipkt_rdy), '0);
    ipkt_vld = '0;
    tick();
    rst_n = 1'b1;

    // Single multicast on port 2.
    ipkt_vld = 4'b0100;
    ipkt_data[PB*2 +: PB] = 72'h0000_0000_0001_0800_00;
    exp_q.push_back(72'h0000_0000_0001_0800_00);
    chk_rdy("t1_rdy", 4'b0100);
    tick();
    ipkt_vld = '0;
    #1;
    check("t1_lat_vld", PB'(opkt_vld), PB'(1));
    check("t1_data", opkt_data, 72'h0000_0000_0001_0800_00);
    tick();

    // All ports valid: rotation 0,1,2,3,0 at one packet per cycle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ipkt_vld = 4'b1111;
      set_all(i);
      exp_q.push_back(mk(i % 4, i));
      chk_rdy($sformatf("t2_rdy%0d", i), 4'(1 << (i % 4)));
      if (i > 0) check($sformatf("t2_vld%0d", i), PB'(opkt_vld), PB'(1));
      tick();
    end
    ipkt_vld = '0;
    tick();
    tick();

    // Non-multicast on port 1: consumed, not forwarded.
`ifdef SPIO_ARB_DROP_CNT_EN
    check("t3_drop0", PB'(drop_cnt), PB'(0));
`endif
    ipkt_vld = 4'b0010;
    ipkt_data[PB*1 +: PB] = 72'h11_2233_4455_6677_8880;
    chk_rdy("t3_rdy", 4'b0010);
    tick();
    ipkt_vld = '0;
    #1;
    check("t3_vld", PB'(opkt_vld), PB'(0));
`ifdef SPIO_ARB_DROP_CNT_EN
    check("t3_drop1", PB'(drop_cnt), PB'(1));
`endif
    tick();

    // Fill from port 3, stall for 5 cycles with ports 0 and 3 waiting.
    ipkt_vld = 4'b1000;
    ipkt_data[PB*3 +: PB] = mk(3, 9);
    exp_q.push_back(mk(3, 9));
    chk_rdy("t4_fill", 4'b1000);
    tick();
    opkt_rdy = 1'b0;
    ipkt_vld = 4'b1001;
    ipkt_data[PB*0 +: PB] = mk(0, 10);
    ipkt_data[PB*3 +: PB] = mk(3, 11);
    for (int i = 0; i < 5; i++) begin
      chk_rdy($sformatf("t4_stall_rdy%0d", i), 4'b0000);
      check($sformatf("t4_stall_data%0d", i), opkt_data, mk(3, 9));
      tick();
    end
    opkt_rdy = 1'b1;
    exp_q.push_back(mk(0, 10));
    chk_rdy("t4_resume", 4'b0001);
    tick();
    ipkt_vld = '0;
    tick();
    tick();

    // Only ports 1 and 3 enabled: alternate 1,3,1,3.
    port_en  = 4'b1010;
    ipkt_vld = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      set_all(20 + i);
      exp_q.push_back(mk((i % 2) ? 3 : 1, 20 + i));
      chk_rdy($sformatf("t5_rdy%0d", i), (i % 2) ? 4'b1000 : 4'b0010);
      tick();
    end
    ipkt_vld = '0;
    port_en  = '1;
    tick();
    tick();

    // Reset while full discards the packet; port 0 wins afterwards.
    opkt_rdy = 1'b0;
    ipkt_vld = 4'b0010;
    ipkt_data[PB*1 +: PB] = mk(1, 30);
    chk_rdy("t6_load", 4'b0010);
    tick();
    ipkt_vld = '0;
    #1;
    check("t6_full", PB'(opkt_vld), PB'(1));
    rst_n    = 1'b0;
    ipkt_vld = 4'b1111;
    chk_rdy("t6_rst_rdy", 4'b0000);
    tick();
    check("t6_rst_vld", PB'(opkt_vld), PB'(0));
    exp_q.delete();
    rst_n    = 1'b1;
    opkt_rdy = 1'b1;
    set_all(40);
    exp_q.push_back(mk(0, 40));
    chk_rdy("t6_prio", 4'b0001);
    tick();
    ipkt_vld = '0;
    repeat (3) tick();

    check("queue_empty", PB'(exp_q.size()), PB'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
